cpu_sequencer: RTL

Instruction sequencer for the 5-bit CPU. Sits directly upstream of the 5-bit program counter: it drives the counter's load, enable and data inputs and consumes its count only via the external address mux it controls. It fetches 8-bit instructions, holds them in an instruction register, and steps a phase FSM that issues memory read/write, accumulator-load, PC increment and PC jump strobes, with a memory-ready handshake on every memory phase.

---
 rtl/cpu_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Instruction sequencer for the 5-bit CPU. Fetches an 8-bit instruction into
// the instruction register, then walks a phase FSM that drives the program
// counter (increment / load), the address mux, memory read/write requests and
// the accumulator load strobe. Every memory phase waits on mem_ready.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst        in   asynchronous, active-high reset
//   mem_rdata  in   [7:0] memory read data, {opcode[7:5], operand[4:0]}
//   mem_ready  in   memory phase completes this cycle
//   acc_zero   in   accumulator == 0 (used only for SKZ)
//   resume     in   leave HALT
//   pc_enable  out  increment the program counter
//   pc_load    out  load the program counter from pc_data
//   pc_data    out  [4:0] counter load value (always the IR operand)
//   addr_sel   out  address mux select: 0 = PC, 1 = IR operand
//   mem_rd     out  memory read request
//   mem_wr     out  memory write request (accumulator -> memory)
//   load_acc   out  accumulator captures ALU result
//   ir_opcode  out  [2:0] IR[7:5]
//   ir_operand out  [4:0] IR[4:0]
//   halted     out  FSM is in HALT
// -----------------------------------------------------------------------------
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    input  logic       acc_zero,
    input  logic       resume,
    output logic       pc_enable,
    output logic       pc_load,
    output logic [4:0] pc_data,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_acc,
    output logic [2:0] ir_opcode,
    output logic [4:0] ir_operand,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IADDR  = 3'd0,
        S_IFETCH = 3'd1,
        S_DECODE = 3'd2,
        S_OADDR  = 3'd3,
        S_OFETCH = 3'd4,
        S_STORE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    state_t     state_r;
    logic [7:0] ir_r;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    // Phase state and instruction register; IR only changes on an accepted fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IADDR;
            ir_r    <= 8'h00;
        end else begin
            case (state_r)
                S_IADDR:  state_r <= S_IFETCH;
                S_IFETCH: begin
                    if (mem_ready) begin
                        ir_r    <= mem_rdata;
                        state_r <= S_DECODE;
                    end
                end
                S_DECODE: state_r <= (ir_r[7:5] == OP_HLT) ? S_HALT : S_OADDR;
                S_OADDR: begin
                    if (is_alu_op(ir_r[7:5])) begin
                        state_r <= S_OFETCH;
                    end else if (ir_r[7:5] == OP_STO) begin
                        state_r <= S_STORE;
                    end else begin
                        // SKZ and JMP finish here; HLT cannot reach this state.
                        state_r <= S_IADDR;
                    end
                end
                S_OFETCH: if (mem_ready) state_r <= S_IADDR;
                S_STORE:  if (mem_ready) state_r <= S_IADDR;
                S_HALT:   if (resume) state_r <= S_IADDR;
                default:  state_r <= S_IADDR;
            endcase
        end
    end

    // Strobe decode. load_acc and the SKZ increment must follow mem_ready and
    // acc_zero in the same cycle, so strobes are decoded from the registered
    // state and IR rather than delayed through another flop. IADDR decodes to
    // all zeros, which gives zero outputs as soon as reset asserts.
    always_comb begin
        pc_enable = 1'b0;
        pc_load   = 1'b0;
        addr_sel  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        load_acc  = 1'b0;
        halted    = 1'b0;
        case (state_r)
            S_IADDR:  addr_sel = 1'b0;
            S_IFETCH: mem_rd = 1'b1;
            S_DECODE: pc_enable = 1'b1;
            S_OADDR: begin
                addr_sel = 1'b1;
                if (ir_r[7:5] == OP_SKZ) begin
                    pc_enable = acc_zero;
                end else if (ir_r[7:5] == OP_JMP) begin
                    pc_load = 1'b1;
                end else begin
                    pc_enable = 1'b0;
                end
            end
            S_OFETCH: begin
                addr_sel = 1'b1;
                mem_rd   = 1'b1;
                load_acc = mem_ready;
            end
            S_STORE: begin
                addr_sel = 1'b1;
                mem_wr   = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default:  halted = 1'b0;
        endcase
    end

    assign ir_opcode  = ir_r[7:5];
    assign ir_operand = ir_r[4:0];
    assign pc_data    = ir_r[4:0];

endmodule
